// File: rtl/d_cache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache controller.
// The slave modport is the cache; the master modport is the CPU plus main memory.
interface d_cache_ctrl_if;
   logic [15:0] d_addr;
   logic        re;
   logic        we;
   logic [15:0] wrt_data;
   logic [15:0] rd_data;
   logic        d_rdy;
   logic        allow_hlt;
   logic [13:0] m_addr;
   logic        m_re;
   logic        m_we;
   logic [63:0] m_wdata;
   logic [63:0] m_rdata;
   logic        m_rdy;

   modport slave (
      input  d_addr, re, we, wrt_data, m_rdata, m_rdy,
      output rd_data, d_rdy, allow_hlt, m_addr, m_re, m_we, m_wdata
   );

   modport master (
      output d_addr, re, we, wrt_data, m_rdata, m_rdy,
      input  rd_data, d_rdy, allow_hlt, m_addr, m_re, m_we, m_wdata
   );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back data cache controller: 8 sets, 4 x 16-bit words per line.
// Hits complete combinationally; misses write back a dirty victim, then fill from memory.
//
// state | meaning
// IDLE  | serving hits, detecting misses
// WB    | writing dirty victim line back to memory
// FILL  | fetching the missed line from memory
module d_cache_ctrl (
   input  logic           clk,
   input  logic           rst_n,
   d_cache_ctrl_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WB   = 2'd1;
   localparam logic [1:0] FILL = 2'd2;

   logic [1:0]  state;
   logic [7:0]  valid;
   logic [7:0]  dirty;
   logic [10:0] tag_store  [8];
   logic [63:0] line_store [8];
   logic [10:0] miss_tag;
   logic [2:0]  miss_idx;

   logic [1:0]  offset;
   logic [2:0]  idx;
   logic [10:0] tag;
   logic        req;
   logic        tag_match;
   logic        hit;
   logic        miss;
   logic [63:0] cur_line;
   logic [15:0] cur_word;

   assign offset    = bus.d_addr[1:0];
   assign idx       = bus.d_addr[4:2];
   assign tag       = bus.d_addr[15:5];
   assign req       = bus.re | bus.we;
   assign tag_match = valid[idx] && (tag_store[idx] == tag);
   assign hit       = req && tag_match && (state == IDLE);
   assign miss      = req && !tag_match && (state == IDLE);
   assign cur_line  = line_store[idx];
   assign cur_word  = cur_line[{offset, 4'b0000} +: 16];

   // Read data reflects the array before any same-cycle write hit lands.
   assign bus.rd_data   = (hit && bus.re) ? cur_word : 16'h0000;
   assign bus.d_rdy     = hit;
   assign bus.allow_hlt = (state == IDLE) && !miss;
   assign bus.m_re      = (state == FILL);
   assign bus.m_we      = (state == WB);
   assign bus.m_wdata   = (state == WB) ? line_store[miss_idx] : 64'h0;

   always_comb begin
      bus.m_addr = 14'h0000;
      case (state)
         WB:      bus.m_addr = {tag_store[miss_idx], miss_idx};
         FILL:    bus.m_addr = {miss_tag, miss_idx};
         default: bus.m_addr = 14'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state    <= IDLE;
         valid    <= 8'h00;
         dirty    <= 8'h00;
         miss_tag <= 11'h000;
         miss_idx <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (hit && bus.we) begin
                  dirty[idx] <= 1'b1;
               end else if (miss) begin
                  miss_tag <= tag;
                  miss_idx <= idx;
                  state    <= (valid[idx] && dirty[idx]) ? WB : FILL;
               end
            end
            WB: begin
               if (bus.m_rdy) begin
                  dirty[miss_idx] <= 1'b0;
                  state           <= FILL;
               end
            end
            FILL: begin
               if (bus.m_rdy) begin
                  valid[miss_idx] <= 1'b1;
                  dirty[miss_idx] <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Arrays carry no reset; reset only blocks writes so an abandoned fill leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (hit && bus.we) begin
            line_store[idx][{offset, 4'b0000} +: 16] <= bus.wrt_data;
         end else if ((state == FILL) && bus.m_rdy) begin
            line_store[miss_idx] <= bus.m_rdata;
            tag_store[miss_idx]  <= miss_tag;
         end
      end
   end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed self-checking bench for d_cache_ctrl: hits, misses, write-back, reset abort, latency sweep.
module tb_d_cache_ctrl;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   d_cache_ctrl_if bus();

   d_cache_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Serves one memory operation already in progress, pulsing m_rdy on cycle lat.
   task automatic mem_op(input logic exp_we, input logic [13:0] exp_addr,
                         input logic [63:0] exp_wdata, input logic [63:0] rdata, input int lat);
      for (int i = 1; i <= lat; i++) begin
         if (i == lat) begin
            bus.m_rdy   = 1'b1;
            bus.m_rdata = rdata;
         end
         @(negedge clk);
         n_tests++;
         if (bus.m_we !== exp_we || bus.m_re !== !exp_we) begin
            n_fail++;
            $display("FAIL mem_strobes cyc %0d: m_we=%b m_re=%b, expected m_we=%b m_re=%b",
                     i, bus.m_we, bus.m_re, exp_we, !exp_we);
         end
         n_tests++;
         if (bus.m_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL mem_addr cyc %0d: got %h expected %h", i, bus.m_addr, exp_addr);
         end
         n_tests++;
         if (bus.d_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_drdy cyc %0d: got %b expected 0", i, bus.d_rdy);
         end
         if (exp_we) begin
            n_tests++;
            if (bus.m_wdata !== exp_wdata) begin
               n_fail++;
               $display("FAIL mem_wdata: got %h expected %h", bus.m_wdata, exp_wdata);
            end
         end
         step();
         bus.m_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.m_re !== 1'b0 || bus.m_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mem: m_re=%b m_we=%b expected 0 0", bus.m_re, bus.m_we);
      end
      n_tests++;
      if (bus.d_rdy !== 1'b0 || bus.rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_cpu: d_rdy=%b rd_data=%h expected 0 0000", bus.d_rdy, bus.rd_data);
      end
      n_tests++;
      if (bus.allow_hlt !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hlt: got %b expected 1", bus.allow_hlt);
      end
   endtask

   task automatic test_read_miss();
      bus.d_addr = 16'h0024;
      bus.re     = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b0 || bus.allow_hlt !== 1'b0 || bus.rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL miss_detect: d_rdy=%b allow_hlt=%b rd_data=%h expected 0 0 0000",
                  bus.d_rdy, bus.allow_hlt, bus.rd_data);
      end
      step();
      mem_op(1'b0, 14'h0009, 64'h0, 64'h4444_3333_2222_BEEF, 3);
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL miss_complete: d_rdy=%b rd_data=%h expected 1 beef", bus.d_rdy, bus.rd_data);
      end
      step();
   endtask

   task automatic test_write_hit();
      bus.re       = 1'b0;
      bus.we       = 1'b1;
      bus.d_addr   = 16'h0025;
      bus.wrt_data = 16'h1234;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.m_re !== 1'b0 || bus.m_we !== 1'b0 || bus.rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_hit: d_rdy=%b m_re=%b m_we=%b rd_data=%h expected 1 0 0 0000",
                  bus.d_rdy, bus.m_re, bus.m_we, bus.rd_data);
      end
      step();
      bus.we = 1'b0;
      bus.re = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'h1234 || bus.m_re !== 1'b0) begin
         n_fail++;
         $display("FAIL read_after_write: d_rdy=%b rd_data=%h m_re=%b expected 1 1234 0",
                  bus.d_rdy, bus.rd_data, bus.m_re);
      end
      step();
      bus.we       = 1'b1;
      bus.d_addr   = 16'h0026;
      bus.wrt_data = 16'h5555;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'h3333) begin
         n_fail++;
         $display("FAIL rw_prewrite: d_rdy=%b rd_data=%h expected 1 3333", bus.d_rdy, bus.rd_data);
      end
      step();
      bus.we = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.rd_data !== 16'h5555) begin
         n_fail++;
         $display("FAIL rw_postwrite: got %h expected 5555", bus.rd_data);
      end
      step();
      bus.re = 1'b0;
   endtask

   task automatic test_dirty_conflict();
      bus.d_addr = 16'h0424;
      bus.re     = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b0 || bus.m_we !== 1'b0) begin
         n_fail++;
         $display("FAIL dirty_detect: d_rdy=%b m_we=%b expected 0 0", bus.d_rdy, bus.m_we);
      end
      step();
      mem_op(1'b1, 14'h0009, 64'h4444_5555_1234_BEEF, 64'h0, 4);
      mem_op(1'b0, 14'h0109, 64'h0, 64'hDDDD_CCCC_BBBB_AAAA, 2);
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL dirty_complete: d_rdy=%b rd_data=%h expected 1 aaaa", bus.d_rdy, bus.rd_data);
      end
      step();
      bus.re = 1'b0;
   endtask

   task automatic test_clean_conflict();
      bus.d_addr = 16'h0027;
      bus.re     = 1'b1;
      step();
      // Request dropped and redirected mid-miss; the latched line must still fill.
      bus.re     = 1'b0;
      bus.d_addr = 16'h0048;
      mem_op(1'b0, 14'h0009, 64'h0, 64'h7777_6666_5555_4444, 5);
      @(negedge clk);
      n_tests++;
      if (bus.allow_hlt !== 1'b1 || bus.d_rdy !== 1'b0 || bus.rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL clean_idle: allow_hlt=%b d_rdy=%b rd_data=%h expected 1 0 0000",
                  bus.allow_hlt, bus.d_rdy, bus.rd_data);
      end
      bus.m_rdy   = 1'b1;
      bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      bus.m_rdy  = 1'b0;
      bus.re     = 1'b1;
      bus.d_addr = 16'h0027;
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'h7777 || bus.m_re !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_hit: d_rdy=%b rd_data=%h m_re=%b expected 1 7777 0",
                  bus.d_rdy, bus.rd_data, bus.m_re);
      end
      step();
      bus.re = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      bus.d_addr = 16'h0048;
      bus.re     = 1'b1;
      step();
      @(negedge clk);
      n_tests++;
      if (bus.m_re !== 1'b1 || bus.m_addr !== 14'h0012) begin
         n_fail++;
         $display("FAIL abort_fill_start: m_re=%b m_addr=%h expected 1 0012", bus.m_re, bus.m_addr);
      end
      rst_n       = 1'b1;
      bus.m_rdy   = 1'b1;
      bus.m_rdata = 64'h0000_0000_0000_9999;
      step();
      rst_n     = 1'b0;
      bus.m_rdy = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.m_re !== 1'b0 || bus.d_rdy !== 1'b0 || bus.allow_hlt !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_after_reset: m_re=%b d_rdy=%b allow_hlt=%b expected 0 0 0",
                  bus.m_re, bus.d_rdy, bus.allow_hlt);
      end
      step();
      mem_op(1'b0, 14'h0012, 64'h0, 64'h0000_0000_0000_8888, 2);
      @(negedge clk);
      n_tests++;
      if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'h8888) begin
         n_fail++;
         $display("FAIL abort_refill: d_rdy=%b rd_data=%h expected 1 8888", bus.d_rdy, bus.rd_data);
      end
      step();
      bus.re = 1'b0;
   endtask

   task automatic test_latency();
      logic [10:0] t;
      logic [10:0] prev_tag;
      logic        prev_dirty;
      prev_dirty = 1'b0;
      prev_tag   = 11'h000;
      for (int lat = 1; lat <= 10; lat++) begin
         t          = 11'h010 + 11'(lat);
         bus.d_addr = {t, 3'd3, 2'd0};
         bus.re     = 1'b1;
         bus.we     = 1'b0;
         step();
         if (prev_dirty)
            mem_op(1'b1, {prev_tag, 3'd3}, {48'h0, 16'hC000 + 16'(lat - 1)}, 64'h0, lat);
         mem_op(1'b0, {t, 3'd3}, 64'h0, {48'h0, 16'hA000 + 16'(lat)}, lat);
         @(negedge clk);
         n_tests++;
         if (bus.d_rdy !== 1'b1 || bus.rd_data !== 16'hA000 + 16'(lat)) begin
            n_fail++;
            $display("FAIL lat_%0d_read: d_rdy=%b rd_data=%h expected 1 %h",
                     lat, bus.d_rdy, bus.rd_data, 16'hA000 + 16'(lat));
         end
         step();
         if (lat % 2 == 0) begin
            bus.re       = 1'b0;
            bus.we       = 1'b1;
            bus.wrt_data = 16'hC000 + 16'(lat);
            @(negedge clk);
            n_tests++;
            if (bus.d_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL lat_%0d_write: d_rdy=%b expected 1", lat, bus.d_rdy);
            end
            step();
            bus.we     = 1'b0;
            prev_dirty = 1'b1;
         end else begin
            prev_dirty = 1'b0;
         end
         prev_tag = t;
      end
      bus.re = 1'b0;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b1;
      bus.d_addr   = 16'h0000;
      bus.re       = 1'b0;
      bus.we       = 1'b0;
      bus.wrt_data = 16'h0000;
      bus.m_rdata  = 64'h0;
      bus.m_rdy    = 1'b0;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_dirty_conflict();
      test_clean_conflict();
      test_reset_mid_fill();
      test_latency();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/d_cache_ctrl.md
D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

Interface
REQ-001 Parameters: none; geometry fixed at 8 sets, direct-mapped, 4 x 16-bit words per line.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-high (asserted = 1), sampled on rising clk.
REQ-004 d_addr  in  16  CPU word address; offset [1:0], index [4:2], tag [15:5].
REQ-005 re  in  1  CPU read request, held until d_rdy.
REQ-006 we  in  1  CPU write request, held until d_rdy.
REQ-007 wrt_data  in  16  CPU write data.
REQ-008 rd_data  out  16  read word; valid when d_rdy && re.
REQ-009 d_rdy  out  1  request complete this cycle.
REQ-010 allow_hlt  out  1  no miss in progress and no dirty write-back pending.
REQ-011 m_addr  out  14  line address to main memory ({tag,index}).
REQ-012 m_re  out  1  line fill request.
REQ-013 m_we  out  1  line write-back request.
REQ-014 m_wdata  out  64  victim line; word 0 in [15:0].
REQ-015 m_rdata  in  64  fill line; word 0 in [15:0].
REQ-016 m_rdy  in  1  one-cycle pulse: memory op complete; m_rdata valid that cycle for reads.

Function
REQ-017 Hit = (re||we) && valid[index] && tag_store[index]==d_addr[15:5], with state IDLE.
REQ-018 Hit path is combinational: d_rdy=1 and rd_data=selected word in the same cycle as the request.
REQ-019 Write hit updates addressed word and sets dirty[index] on the clock edge where d_rdy=1.
REQ-020 re and we both high: treated as a write; rd_data still returns pre-write word.
REQ-021 rd_data = 16'h0000 whenever d_rdy=0 or re=0.
REQ-022 States: IDLE, WB, FILL.
REQ-023 IDLE, request misses, victim dirty -> WB; victim clean or invalid -> FILL; miss tag/index latched at transition.
REQ-024 WB: m_we=1, m_addr={victim tag,index}, m_wdata=victim line, held until m_rdy; on m_rdy -> FILL, dirty[index] cleared.
REQ-025 FILL: m_re=1, m_addr={latched tag,index}, held until m_rdy; on m_rdy line written from m_rdata, valid=1, dirty=0, tag stored -> IDLE.
REQ-026 m_re and m_we never asserted together; both 0 in IDLE.
REQ-027 d_rdy=0 in WB and FILL; request completes as a hit the cycle after return to IDLE (miss latency = memory cycles + 1).
REQ-028 CPU changing/dropping request mid-miss does not abort the miss; latched line is filled, new request evaluated in IDLE.
REQ-029 m_rdy in IDLE ignored.
REQ-030 allow_hlt=1 iff state IDLE and no request is missing; dirty lines do not block halt.

Reset
REQ-031 rst_n=1: state IDLE, all valid and dirty bits 0, m_re=m_we=0, d_rdy=0, rd_data=0, allow_hlt=1 next cycle.
REQ-032 Reset during WB or FILL abandons the operation; outstanding memory op is dropped, no line written.
REQ-033 Tag/data arrays need no reset value; invalidity guaranteed by valid bits.

Verification
REQ-034 After reset, re=1, d_addr=16'h0024 -> d_rdy=0, FILL with m_addr=14'h0009; m_rdy with m_rdata word0=16'hBEEF -> next cycle d_rdy=1, rd_data=16'hBEEF.
REQ-035 Write hit d_addr=16'h0025, wrt_data=16'h1234 -> d_rdy same cycle; subsequent read of 16'h0025 returns 16'h1234, no m_re.
REQ-036 Read 16'h0424 (same index 1, different tag) after REQ-035 -> WB first: m_we=1, m_addr=14'h0009, m_wdata[31:16]=16'h1234; then FILL m_addr=14'h0109.
REQ-037 Clean conflict miss -> no m_we pulse, FILL directly.
REQ-038 rst_n=1 asserted mid-FILL -> m_re=0 next cycle; read of same address misses again.
REQ-039 Memory latency varied 1..10 cycles -> m_re/m_we held stable until m_rdy, never both high.
